// File: rtl/btn_conditioner_pkg.sv
// btn_conditioner_pkg: shared button constants, arbitration outcomes and index encoder
package btn_conditioner_pkg;
  localparam int NUM_BTN = 4;
  localparam int TICKS_PER_MILLI_DEF = 25000;
  localparam int DEBOUNCE_MS_DEF = 10;
  typedef enum logic [1:0] {BTN_GREEN = 2'd0, BTN_RED = 2'd1, BTN_YELLOW = 2'd2, BTN_BLUE = 2'd3} btn_idx_e;
  typedef enum logic [1:0] {ARB_NONE, ARB_VALID, ARB_MULTI} arb_e;
  function automatic btn_idx_e onehot_idx(input logic [NUM_BTN-1:0] v);
    btn_idx_e idx;
    idx = BTN_GREEN;
    for (int i = 0; i < NUM_BTN; i++)
      if (v[i]) idx = btn_idx_e'(2'(i));
    return idx;
  endfunction
endpackage

// File: rtl/btn_conditioner_if.sv
// btn_conditioner_if: raw pins in, debounced levels and press/release/choice events out
interface btn_conditioner_if;
  import btn_conditioner_pkg::*;
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_lvl;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [1:0] code;
  logic code_valid;
  logic multi;
  modport master(output btn_raw, input btn_lvl, btn_press, btn_release, code, code_valid, multi);
  modport slave(input btn_raw, output btn_lvl, btn_press, btn_release, code, code_valid, multi);
endinterface

// File: rtl/btn_conditioner_debounce_ch.sv
// btn_debounce_ch: two-flop synchroniser, N-cycle debounce counter and registered edge pulses
module btn_debounce_ch #(
  parameter int N = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic lvl,
  output logic press,
  output logic rel,
  output logic rise
);
  localparam int CW = $clog2(N + 1);
  logic s1_q, s1_d, s2_q, s2_d, lvl_q, lvl_d, press_q, press_d, rel_q, rel_d, flip;
  logic [CW-1:0] cnt_q, cnt_d;
  // rise is combinational so the arbiter decides on the same edge the level flips
  always_comb begin
    s1_d = raw;
    s2_d = s1_q;
    flip = (s2_q != lvl_q) && (cnt_q == CW'(N - 1));
    cnt_d = (s2_q == lvl_q || flip) ? '0 : cnt_q + CW'(1);
    lvl_d = lvl_q ^ flip;
    rise = flip & ~lvl_q;
    press_d = rise;
    rel_d = flip & lvl_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      cnt_q <= '0;
      lvl_q <= 1'b0;
      press_q <= 1'b0;
      rel_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
      press_q <= press_d;
      rel_q <= rel_d;
    end
  end
  assign lvl = lvl_q;
  assign press = press_q;
  assign rel = rel_q;
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: four debounced button channels plus single-press arbitration and encoding
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int TICKS_PER_MILLI = TICKS_PER_MILLI_DEF,
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF
) (
  input logic clk,
  input logic rst,
  btn_conditioner_if.slave bus
);
  localparam int N = TICKS_PER_MILLI * DEBOUNCE_MS;
  logic [NUM_BTN-1:0] lvl, press, rel, rise;
  logic [1:0] code_q, code_d;
  logic cv_q, cv_d, multi_q, multi_d;
  arb_e arb;
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(.N(N)) u_ch (
      .clk(clk),
      .rst(rst),
      .raw(bus.btn_raw[i]),
      .lvl(lvl[i]),
      .press(press[i]),
      .rel(rel[i]),
      .rise(rise[i])
    );
  end
  // lvl is the pre-edge level, so any set bit is a button already held
  always_comb begin
    arb = (rise == '0) ? ARB_NONE : ($countones(rise) == 1 && lvl == '0) ? ARB_VALID : ARB_MULTI;
    code_d = (arb == ARB_VALID) ? onehot_idx(rise) : code_q;
    cv_d = arb == ARB_VALID;
    multi_d = arb == ARB_MULTI;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q <= 2'd0;
      cv_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      code_q <= code_d;
      cv_q <= cv_d;
      multi_q <= multi_d;
    end
  end
  assign bus.btn_lvl = lvl;
  assign bus.btn_press = press;
  assign bus.btn_release = rel;
  assign bus.code = code_q;
  assign bus.code_valid = cv_q;
  assign bus.multi = multi_q;
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed and random stimulus, event scoreboard against a streak-count model
module tb_btn_conditioner;
  import btn_conditioner_pkg::*;
  localparam int TPM = 10;
  localparam int DMS = 2;
  localparam int N = TPM * DMS;
  typedef struct {
    int cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [1:0] code;
    logic cv;
    logic multi;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  ev_t exp_q[$];
  logic [3:0] hist[$];
  int streak[4];
  logic [3:0] m_lvl = 4'h0;
  logic [1:0] m_code = 2'd0;
  ev_t m_ev, mon_ev;
  btn_conditioner_if bus();
  btn_conditioner #(.TICKS_PER_MILLI(TPM), .DEBOUNCE_MS(DMS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask
  // Model: the level flips once the doubly-delayed pin has disagreed with it for N edges running
  always @(posedge clk) begin : model
    logic [3:0] s2p, rises, falls, old;
    logic single;
    cyc++;
    if (rst) begin
      hist = '{4'h0, 4'h0};
      m_lvl = 4'h0;
      m_code = 2'd0;
      for (int i = 0; i < 4; i++) streak[i] = 0;
    end else begin
      s2p = hist[0];
      hist.push_back(bus.btn_raw);
      void'(hist.pop_front());
      old = m_lvl;
      rises = 4'h0;
      falls = 4'h0;
      for (int i = 0; i < 4; i++) begin
        if (s2p[i] != m_lvl[i]) begin
          streak[i]++;
          if (streak[i] == N) begin
            streak[i] = 0;
            m_lvl[i] = ~m_lvl[i];
            if (m_lvl[i]) rises[i] = 1'b1;
            else falls[i] = 1'b1;
          end
        end else streak[i] = 0;
      end
      if ((rises | falls) != 4'h0) begin
        single = $countones(rises) == 1 && old == 4'h0;
        if (single)
          for (int j = 0; j < 4; j++)
            if (rises[j]) m_code = 2'(j);
        m_ev.cyc = cyc;
        m_ev.press = rises;
        m_ev.rel = falls;
        m_ev.cv = single;
        m_ev.multi = rises != 4'h0 && !single;
        m_ev.code = m_code;
        exp_q.push_back(m_ev);
      end
    end
  end
  always @(negedge clk) begin
    chk("lvl", 32'(bus.btn_lvl), 32'(m_lvl));
    chk("code", 32'(bus.code), 32'(m_code));
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      chk("missed_event_cycle", 32'(cyc), 32'(exp_q[0].cyc));
      void'(exp_q.pop_front());
    end
    if (bus.btn_press != 4'h0 || bus.btn_release != 4'h0 || bus.code_valid || bus.multi) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 32'({bus.btn_press, bus.btn_release, bus.code_valid, bus.multi}), 32'(0));
      end else begin
        mon_ev = exp_q.pop_front();
        chk("ev_cycle", 32'(cyc), 32'(mon_ev.cyc));
        chk("ev_press", 32'(bus.btn_press), 32'(mon_ev.press));
        chk("ev_release", 32'(bus.btn_release), 32'(mon_ev.rel));
        chk("ev_code_valid", 32'(bus.code_valid), 32'(mon_ev.cv));
        chk("ev_multi", 32'(bus.multi), 32'(mon_ev.multi));
        chk("ev_code", 32'(bus.code), 32'(mon_ev.code));
      end
    end
  end
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    bus.btn_raw = 4'h0;
    rst = 1'b1;
    wait_cyc(3);
    chk("reset_lvl", 32'(bus.btn_lvl), 32'(0));
    chk("reset_cv", 32'(bus.code_valid), 32'(0));
    rst = 1'b0;
    wait_cyc(5);
    // clean press of button 2
    bus.btn_raw[2] = 1'b1;
    wait_cyc(N + 1);
    chk("t1_no_early_press", 32'(bus.btn_press[2]), 32'(0));
    wait_cyc(1);
    chk("t1_press", 32'(bus.btn_press[2]), 32'(1));
    chk("t1_code_valid", 32'(bus.code_valid), 32'(1));
    chk("t1_code", 32'(bus.code), 32'(2));
    wait_cyc(1);
    chk("t1_pulse_width", 32'(bus.btn_press[2]), 32'(0));
    wait_cyc(100 - N - 3);
    bus.btn_raw[2] = 1'b0;
    wait_cyc(N + 1);
    chk("t1_lvl_held", 32'(bus.btn_lvl[2]), 32'(1));
    wait_cyc(1);
    chk("t1_release", 32'(bus.btn_release[2]), 32'(1));
    chk("t1_lvl_low", 32'(bus.btn_lvl[2]), 32'(0));
    wait_cyc(30);
    // bouncing button 1 then a steady hold
    for (int t = 0; t < 60; t++) begin
      bus.btn_raw[1] = ((t / 7) % 2) == 0;
      wait_cyc(1);
    end
    bus.btn_raw[1] = 1'b1;
    wait_cyc(60);
    chk("t2_lvl", 32'(bus.btn_lvl[1]), 32'(1));
    bus.btn_raw[1] = 1'b0;
    wait_cyc(40);
    // short glitches on button 0
    bus.btn_raw[0] = 1'b1;
    wait_cyc(19);
    bus.btn_raw[0] = 1'b0;
    wait_cyc(40);
    chk("t3_glitch19_lvl", 32'(bus.btn_lvl[0]), 32'(0));
    bus.btn_raw[0] = 1'b1;
    wait_cyc(21);
    bus.btn_raw[0] = 1'b0;
    wait_cyc(3);
    chk("t3_hold21_lvl", 32'(bus.btn_lvl[0]), 32'(1));
    wait_cyc(40);
    // make code 2 before the simultaneous press
    bus.btn_raw[2] = 1'b1;
    wait_cyc(30);
    bus.btn_raw[2] = 1'b0;
    wait_cyc(40);
    bus.btn_raw[0] = 1'b1;
    bus.btn_raw[3] = 1'b1;
    wait_cyc(N + 2);
    chk("t4_press", 32'(bus.btn_press), 32'(4'b1001));
    chk("t4_multi", 32'(bus.multi), 32'(1));
    chk("t4_code_valid", 32'(bus.code_valid), 32'(0));
    chk("t4_code", 32'(bus.code), 32'(2));
    bus.btn_raw = 4'h0;
    wait_cyc(40);
    // overlapping press: 1 held, then 2
    bus.btn_raw[1] = 1'b1;
    wait_cyc(40);
    bus.btn_raw[2] = 1'b1;
    wait_cyc(N + 2);
    chk("t5_press", 32'(bus.btn_press[2]), 32'(1));
    chk("t5_multi", 32'(bus.multi), 32'(1));
    chk("t5_code_valid", 32'(bus.code_valid), 32'(0));
    chk("t5_code", 32'(bus.code), 32'(1));
    bus.btn_raw = 4'h0;
    wait_cyc(50);
    // reset mid-debounce with button 3 held
    bus.btn_raw[3] = 1'b1;
    wait_cyc(17);
    rst = 1'b1;
    wait_cyc(1);
    chk("t6_rst_lvl", 32'(bus.btn_lvl), 32'(0));
    chk("t6_rst_press", 32'(bus.btn_press), 32'(0));
    chk("t6_rst_code", 32'(bus.code), 32'(0));
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(N + 1);
    chk("t6_no_early_press", 32'(bus.btn_press[3]), 32'(0));
    wait_cyc(1);
    chk("t6_press", 32'(bus.btn_press[3]), 32'(1));
    chk("t6_code_valid", 32'(bus.code_valid), 32'(1));
    chk("t6_code", 32'(bus.code), 32'(3));
    bus.btn_raw = 4'h0;
    wait_cyc(40);
    // random pin activity with occasional resets
    for (int r = 0; r < 150; r++) begin
      if ($urandom_range(0, 2) == 0) bus.btn_raw = 4'($urandom);
      else bus.btn_raw[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        wait_cyc($urandom_range(1, 3));
        rst = 1'b0;
      end
      wait_cyc($urandom_range(1, 60));
    end
    bus.btn_raw = 4'h0;
    wait_cyc(3 * N);
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
